// File: rtl/uart_cmd_initiator_if.sv
`default_nettype none
// ============================================================================
// Module : uart_cmd_initiator_if
// Byte-level Tx_uart / Rx_uart handshake bundle for the command initiator.
// Rev    : 1.0
// ============================================================================
interface uart_cmd_initiator_if #(
    parameter int NB_BITS = 8
);
    logic [NB_BITS-1:0] tx_data;
    logic               tx_start;
    logic               tx_done;
    logic [NB_BITS-1:0] rx_data;
    logic               rx_done;

    // master: the initiator; slave: the Tx/Rx UART pair it talks to
    modport master (
        output tx_data,
        output tx_start,
        input  tx_done,
        input  rx_data,
        input  rx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_done,
        output rx_data,
        output rx_done
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module : uart_cmd_initiator
// Sends A, B, opcode through Tx_uart, then waits for one Rx_uart reply byte.
// Rev    : 1.0
// ============================================================================
module uart_cmd_initiator #(
    parameter int NB_BITS        = 8,
    parameter int NB_TIMEOUT     = 24,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  wire logic               i_clk,
    input  wire logic               i_rst,
    input  wire logic               i_start,
    input  wire logic [NB_BITS-1:0] i_op_a,
    input  wire logic [NB_BITS-1:0] i_op_b,
    input  wire logic [NB_BITS-1:0] i_opcode,
    output logic                    o_busy,
    output logic [NB_BITS-1:0]      o_result,
    output logic                    o_valid,
    output logic                    o_timeout,
    uart_cmd_initiator_if.master    link
);

    localparam logic [NB_TIMEOUT-1:0] c_TERM_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]            c_LAST_IDX   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_TX = 2'd2,
        ST_WAIT_RX = 2'd3
    } state_t;

    state_t              r_state,   w_state_next;
    logic [1:0]          r_idx,     w_idx_next;
    logic [NB_TIMEOUT-1:0] r_cnt,   w_cnt_next;
    logic [NB_BITS-1:0]  r_op_a,    w_op_a_next;
    logic [NB_BITS-1:0]  r_op_b,    w_op_b_next;
    logic [NB_BITS-1:0]  r_opcode,  w_opcode_next;
    logic [NB_BITS-1:0]  r_result,  w_result_next;
    logic                r_valid,   w_valid_next;
    logic                r_timeout, w_timeout_next;
    logic [NB_BITS-1:0]  w_tx_byte;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_opcode  <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_cnt     <= w_cnt_next;
            r_op_a    <= w_op_a_next;
            r_op_b    <= w_op_b_next;
            r_opcode  <= w_opcode_next;
            r_result  <= w_result_next;
            r_valid   <= w_valid_next;
            r_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_cnt_next     = r_cnt;
        w_op_a_next    = r_op_a;
        w_op_b_next    = r_op_b;
        w_opcode_next  = r_opcode;
        w_result_next  = r_result;
        w_valid_next   = 1'b0;
        w_timeout_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_op_a_next   = i_op_a;
                    w_op_b_next   = i_op_b;
                    w_opcode_next = i_opcode;
                    w_idx_next    = 2'd0;
                    w_state_next  = ST_SEND;
                end
            end
            ST_SEND: begin
                w_state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (link.tx_done) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_WAIT_RX;
                    end else begin
                        w_idx_next   = r_idx + 2'd1;
                        w_state_next = ST_SEND;
                    end
                end
            end
            ST_WAIT_RX: begin
                w_cnt_next = r_cnt + NB_TIMEOUT'(1);
                // A reply landing on the terminal count still counts as a reply
                if (link.rx_done) begin
                    w_result_next = link.rx_data;
                    w_valid_next  = 1'b1;
                    w_state_next  = ST_IDLE;
                end else if (r_cnt == c_TERM_COUNT) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        case (r_idx)
            2'd0:    w_tx_byte = r_op_a;
            2'd1:    w_tx_byte = r_op_b;
            default: w_tx_byte = r_opcode;
        endcase
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign link.tx_start = (r_state == ST_SEND);
    assign link.tx_data  = w_tx_byte;
    assign o_result      = r_result;
    assign o_valid       = r_valid;
    assign o_timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_cmd_initiator
// Randomized self-checking bench with Tx/Rx responder stubs and a frame model.
// Rev    : 1.0
// ============================================================================
module tb_uart_cmd_initiator;

    localparam int NB = 8;
    localparam int TO = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_start = 1'b0;
    logic [NB-1:0] i_op_a = '0, i_op_b = '0, i_opcode = '0;
    logic          o_busy, o_valid, o_timeout;
    logic [NB-1:0] o_result;

    uart_cmd_initiator_if #(.NB_BITS(NB)) link ();

    uart_cmd_initiator #(
        .NB_BITS        (NB),
        .NB_TIMEOUT     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_start   (i_start),
        .i_op_a    (i_op_a),
        .i_op_b    (i_op_b),
        .i_opcode  (i_opcode),
        .o_busy    (o_busy),
        .o_result  (o_result),
        .o_valid   (o_valid),
        .o_timeout (o_timeout),
        .link      (link)
    );

    always #5 clk = ~clk;

    int            n_checks = 0, n_fail = 0;
    int            cyc = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] exp_result = '0;
    int            exp_valid_cnt = 0, exp_timeout_cnt = 0;
    int            valid_cnt = 0, timeout_cnt = 0;
    int            tx_start_cnt = 0, tx_done_cnt = 0;
    int            samp_cyc = 0, done_base = 0, start_base = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Tx_uart stub: acknowledge each request after 1..4 cycles
    initial begin
        link.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (link.tx_start === 1'b1) begin
                repeat ($urandom_range(4, 1)) @(posedge clk);
                #1 link.tx_done = 1'b1;
                @(posedge clk);
                #1 link.tx_done = 1'b0;
            end
        end
    end

    // Monitor: compare every transmitted byte against the expected frame order
    initial begin
        logic prev_valid, prev_timeout;
        prev_valid   = 1'b0;
        prev_timeout = 1'b0;
        forever begin
            @(negedge clk);
            if (link.tx_start === 1'b1) begin
                tx_start_cnt++;
                if (exp_q.size() == 0) chk("tx_unexpected", 32'(exp_q.size()), 32'd1);
                else                   chk("tx_byte", link.tx_data, exp_q.pop_front());
            end
            if (link.tx_done === 1'b1) begin
                tx_done_cnt++;
                samp_cyc = cyc + 1;
            end
            if (o_valid === 1'b1) begin
                valid_cnt++;
                chk("valid_one_cycle", prev_valid, 1'b0);
                chk("valid_excl_timeout", o_timeout, 1'b0);
            end
            if (o_timeout === 1'b1) begin
                timeout_cnt++;
                chk("timeout_one_cycle", prev_timeout, 1'b0);
            end
            prev_valid   = o_valid;
            prev_timeout = o_timeout;
        end
    end

    task automatic push_frame(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] op);
        i_start  = 1'b1;
        i_op_a   = a;
        i_op_b   = b;
        i_opcode = op;
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(op);
        done_base  = tx_done_cnt;
        start_base = tx_start_cnt;
    endtask

    task automatic start_frame(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] op);
        @(posedge clk); #1;
        push_frame(a, b, op);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (tx_done_cnt < done_base + 3 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (tx_done_cnt < done_base + 3) chk("frame_done_bound", tx_done_cnt, done_base + 3);
        @(posedge clk); #1;
    endtask

    // k = idle cycles before the reply; k >= TO means the reply comes too late
    task automatic finish_txn(input int k, input logic [NB-1:0] rx);
        int n;
        wait_frame();
        if (k <= TO - 1) begin
            repeat (k) begin @(posedge clk); #1; end
            link.rx_data = rx;
            link.rx_done = 1'b1;
            @(posedge clk); #1;
            link.rx_done = 1'b0;
            exp_valid_cnt++;
            exp_result = rx;
            chk("valid", o_valid, 1'b1);
            chk("result", o_result, exp_result);
            chk("busy_drop", o_busy, 1'b0);
            chk("no_timeout", o_timeout, 1'b0);
        end else begin
            n = 0;
            while (o_timeout !== 1'b1 && n < TO + 20) begin
                @(posedge clk); #1;
                n++;
            end
            exp_timeout_cnt++;
            chk("timeout_seen", o_timeout, 1'b1);
            chk("timeout_cycle", cyc, samp_cyc + TO);
            chk("timeout_result_kept", o_result, exp_result);
            chk("timeout_busy_drop", o_busy, 1'b0);
            link.rx_data = rx;
            link.rx_done = 1'b1;
            @(posedge clk); #1;
            link.rx_done = 1'b0;
            chk("late_rx_no_valid", o_valid, 1'b0);
            chk("late_rx_result_kept", o_result, exp_result);
        end
        chk("frame_len", tx_start_cnt - start_base, 3);
        chk("frame_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},     o_busy,        1'b0);
        chk({tag, "_tx_start"}, link.tx_start, 1'b0);
        chk({tag, "_tx_data"},  link.tx_data,  '0);
        chk({tag, "_result"},   o_result,      '0);
        chk({tag, "_valid"},    o_valid,       1'b0);
        chk({tag, "_timeout"},  o_timeout,     1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [NB-1:0] a2;
        link.rx_data = '0;
        link.rx_done = 1'b0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Normal transaction
        start_frame(8'h12, 8'h34, 8'h20);
        finish_txn($urandom_range(10, 0), 8'h46);

        // Timeout, then a late reply that must be ignored
        start_frame(8'hA1, 8'hB2, 8'hC3);
        finish_txn(TO + 4, 8'h99);

        // Spurious rx during SEND and a re-start during WAIT_TX
        start_frame(8'h5C, 8'hC3, 8'h07);
        link.rx_data = 8'hAA;
        link.rx_done = 1'b1;
        @(posedge clk); #1;
        link.rx_done = 1'b0;
        chk("spurious_rx_valid", o_valid, 1'b0);
        chk("spurious_rx_result", o_result, exp_result);
        i_start = 1'b1;
        i_op_a  = 8'hFF;
        @(posedge clk); #1;
        i_start = 1'b0;
        finish_txn(4, 8'h3C);

        // Reply on the terminal-count cycle
        start_frame(8'h01, 8'h02, 8'h03);
        finish_txn(TO - 1, 8'h5A);

        // Reset in the middle of the second byte
        start_frame(8'h77, 8'h88, 8'h99);
        n = 0;
        while (tx_start_cnt < start_base + 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("second_tx_start_seen", tx_start_cnt - start_base, 2);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        exp_result = '0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b1;
        start_frame(8'hE4, 8'h4E, 8'h10);
        finish_txn(3, 8'hC7);

        // Back-to-back: new start accepted in the o_valid cycle
        start_frame(8'h3A, 8'h3B, 8'h3C);
        wait_frame();
        repeat (2) begin @(posedge clk); #1; end
        link.rx_data = 8'h6D;
        link.rx_done = 1'b1;
        @(posedge clk); #1;
        link.rx_done = 1'b0;
        exp_valid_cnt++;
        exp_result = 8'h6D;
        chk("b2b_valid", o_valid, 1'b1);
        chk("b2b_result", o_result, exp_result);
        chk("b2b_frame_len", tx_start_cnt - start_base, 3);
        a2 = 8'($urandom);
        push_frame(a2, 8'($urandom), 8'($urandom));
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("b2b_tx_start", link.tx_start, 1'b1);
        chk("b2b_tx_data", link.tx_data, a2);
        finish_txn($urandom_range(TO - 1, 0), 8'($urandom));

        // Randomized transactions, some of which time out
        for (int t = 0; t < 8; t++) begin
            start_frame(8'($urandom), 8'($urandom), 8'($urandom));
            finish_txn($urandom_range(TO + 4, 0), 8'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("valid_count", valid_cnt, exp_valid_cnt);
        chk("timeout_count", timeout_cnt, exp_timeout_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_initiator.md
Name: uart_cmd_initiator

Overview:
- Host-side initiator for the UART command link; it is the requesting end of the byte-in/byte-out exchange served by the interface circuit.
- On a start request it sends a three-byte command frame (operand A, operand B, opcode) through the existing Tx_uart handshake.
- It then waits for one response byte from Rx_uart and reports that byte as the result, or reports a timeout if no byte arrives in time.
- Used for board self-test and for the loopback bench that pairs two UART endpoints.

Parameters:
- NB_BITS, 8, width of data bytes, operands, opcode and result.
- NB_TIMEOUT, 24, width of the response-timeout counter.
- TIMEOUT_CYCLES, 10000000, number of i_clk cycles to wait for the response byte; must be <= 2^NB_TIMEOUT - 1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  transaction request, sampled only in IDLE.
- i_op_a  in  NB_BITS  operand A, latched on accepted start.
- i_op_b  in  NB_BITS  operand B, latched on accepted start.
- i_opcode  in  NB_BITS  opcode, latched on accepted start.
- o_busy  out  1  high while a transaction is in progress.
- o_tx_data  out  NB_BITS  byte offered to Tx_uart.
- o_tx_start  out  1  one-cycle request to Tx_uart.
- i_tx_done  in  1  one-cycle pulse from Tx_uart at end of frame.
- i_rx_data  in  NB_BITS  byte from Rx_uart.
- i_rx_done  in  1  one-cycle pulse from Rx_uart, byte valid.
- o_result  out  NB_BITS  last received response byte.
- o_valid  out  1  one-cycle pulse, o_result updated.
- o_timeout  out  1  one-cycle pulse, response not received.

Behaviour:
- Reset (i_rst=0, asynchronous): state=IDLE, byte index=0, timeout counter=0, latched operands=0. All outputs are 0: o_busy, o_tx_data, o_tx_start, o_result, o_valid, o_timeout.
- FSM states are IDLE, SEND, WAIT_TX, WAIT_RX. All state registers update on the rising edge of i_clk.
- o_busy = (state != IDLE). o_tx_start = (state == SEND), so it is high for exactly one cycle per byte.
- IDLE: when i_start=1, latch A/B/opcode, set index=0 and go to SEND. i_start sampled at edge n gives o_busy=1 and o_tx_start=1 during cycle n+1.
- SEND: drive o_tx_data with the byte at the current index, in the order A (0), B (1), opcode (2). Go unconditionally to WAIT_TX.
- WAIT_TX: hold o_tx_data stable. On i_tx_done: if index==2, clear the timeout counter and go to WAIT_RX; otherwise increment index and go to SEND.
- WAIT_RX: the counter increments every cycle.
  - On i_rx_done: o_result<=i_rx_data, o_valid=1 for the next cycle, go to IDLE.
  - Else, when counter==TIMEOUT_CYCLES-1: o_timeout=1 for the next cycle, o_result unchanged, go to IDLE.
  - If i_rx_done coincides with the terminal count, i_rx_done wins: valid is raised and timeout is not.
- Ignored inputs:
  - i_start while busy has no effect and is not queued.
  - i_rx_done outside WAIT_RX is discarded, and o_result is unchanged.
  - i_tx_done outside WAIT_TX has no effect.
- o_valid and o_timeout are never both 1. Each pulse lasts exactly one cycle.
- A new i_start may be accepted in the cycle in which o_valid or o_timeout is high, because state is already IDLE.
- Reset asserted mid-transaction aborts immediately to reset values. No partial byte handshake is resumed after reset.
- There is no timeout on i_tx_done; Tx_uart is trusted to complete.

Test Plan (TIMEOUT_CYCLES=16 in bench, Tx/Rx modelled by responder stubs):
- Normal: start with A=0x12, B=0x34, op=0x20. Required: three o_tx_start pulses carrying 0x12, 0x34, 0x20 in order. Reply rx 0x46 -> o_result=0x46, one-cycle o_valid, o_busy drops the same cycle.
- Timeout: complete the frame and send no rx byte. Required: o_timeout pulses exactly 16 cycles after the third i_tx_done is sampled, o_result keeps its previous value, state returns to IDLE.
- Busy and spurious inputs: re-pulse i_start during WAIT_TX with A=0xFF, and pulse i_rx_done=0xAA during SEND. Required: transmitted bytes are unchanged, o_valid stays 0, and only one frame is sent.
- Race: i_rx_done=0x5A arrives on the terminal-count cycle. Required: o_valid=1, o_result=0x5A, o_timeout=0.
- Reset mid-frame: drive i_rst low after the second o_tx_start. Required: all outputs are 0 immediately, without waiting for a clock. A fresh start after release sends A first.
- Back-to-back: assert i_start in the o_valid cycle. Required: the next o_tx_start occurs the following cycle with the new A.
